// File: rtl/ee201_gcd_pkg.sv
// rtl/ee201_gcd_pkg.sv - shared state encodings for the GCD host and engine
// Purpose: one-hot host state encodings (enum + raw constants), the engine's
//          own state encodings so host-side logic and engine models agree, and
//          a small operand helper.
// Ports:   none (package).
package ee201_gcd_pkg;

  localparam logic [5:0] ST_IDLE = 6'b000001;
  localparam logic [5:0] ST_REQ  = 6'b000010;
  localparam logic [5:0] ST_WAIT = 6'b000100;
  localparam logic [5:0] ST_ACKE = 6'b001000;
  localparam logic [5:0] ST_HOLD = 6'b010000;
  localparam logic [5:0] ST_ERR  = 6'b100000;

  typedef enum logic [5:0] {
    H_IDLE = ST_IDLE,
    H_REQ  = ST_REQ,
    H_WAIT = ST_WAIT,
    H_ACKE = ST_ACKE,
    H_HOLD = ST_HOLD,
    H_ERR  = ST_ERR
  } host_state_e;

  // Engine state encodings (one-hot).
  localparam logic [3:0] ENG_I    = 4'b0001;
  localparam logic [3:0] ENG_SUB  = 4'b0010;
  localparam logic [3:0] ENG_MULT = 4'b0100;
  localparam logic [3:0] ENG_DONE = 4'b1000;

  // The engine never reaches DONE with a zero operand.
  function automatic logic is_zero_op(input logic [7:0] a, input logic [7:0] b);
    return (a == 8'd0) || (b == 8'd0);
  endfunction

endpackage

// File: rtl/ee201_gcd_host_if.sv
// rtl/ee201_gcd_host_if.sv - Start/Ack handshake bundle between host and GCD engine
// Purpose: groups the host<->engine signals.
// Ports (members):
//   Start, Ack, Ain[7:0], Bin[7:0]  host -> engine
//   q_I, q_Done, AB_GCD[7:0]        engine -> host
// Modports: master (host side), slave (engine side).
interface ee201_gcd_host_if;

  logic       Start;
  logic       Ack;
  logic [7:0] Ain;
  logic [7:0] Bin;
  logic       q_I;
  logic       q_Done;
  logic [7:0] AB_GCD;

  modport master (
    output Start, Ack, Ain, Bin,
    input  q_I, q_Done, AB_GCD
  );

  modport slave (
    input  Start, Ack, Ain, Bin,
    output q_I, q_Done, AB_GCD
  );

endinterface

// File: rtl/ee201_sat_counter.sv
// rtl/ee201_sat_counter.sv - saturating up-counter
// Purpose: counts enabled cycles, sticks at all-ones.
// Ports:
//   clk      in   clock, rising edge
//   clr      in   synchronous clear (wins over en)
//   en       in   count enable
//   cnt[W]   out  current count
module ee201_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ee201_gcd_host.sv
// rtl/ee201_gcd_host.sv - initiator side of the GCD engine Start/Ack handshake
// Purpose: latches a user operand pair, starts the engine, captures the GCD and
//          the engine latency, holds the result until UserAck. Rejects zero
//          operands without starting the engine and times out a hung engine.
// Ports:
//   Clk, Reset             clock, synchronous active-high reset
//   Go, UserAck            user request / user release of result
//   Ain_in, Bin_in [7:0]   user operands
//   eng (master)           Start/Ack/Ain/Bin out, q_I/q_Done/AB_GCD in
//   Result [7:0]           captured GCD
//   Cycles [CW]            WAIT cycles of last operation
//   Busy, Valid, ZeroOp, Timeout   status
//   q_Idle..q_Err          one-hot state bits
module ee201_gcd_host
  import ee201_gcd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CW             = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Go,
  input  logic                   UserAck,
  input  logic [7:0]             Ain_in,
  input  logic [7:0]             Bin_in,
  ee201_gcd_host_if.master       eng,
  output logic [7:0]             Result,
  output logic [CW-1:0]          Cycles,
  output logic                   Busy,
  output logic                   Valid,
  output logic                   ZeroOp,
  output logic                   Timeout,
  output logic                   q_Idle,
  output logic                   q_Req,
  output logic                   q_Wait,
  output logic                   q_AckE,
  output logic                   q_Hold,
  output logic                   q_Err
);

  // Last WAIT count value before declaring the engine hung.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  host_state_e state_q, state_d;
  logic [7:0]  ain_q, ain_d;
  logic [7:0]  bin_q, bin_d;
  logic [7:0]  result_q, result_d;
  logic        zero_q, zero_d;
  logic        cnt_clr;
  logic        cnt_en;
  logic [CW-1:0] cycles_cnt;

  ee201_sat_counter #(.W(CW)) u_cycles (
    .clk (Clk),
    .clr (Reset | cnt_clr),
    .en  (cnt_en),
    .cnt (cycles_cnt)
  );

  always_comb begin
    state_d  = state_q;
    ain_d    = ain_q;
    bin_d    = bin_q;
    result_d = result_q;
    zero_d   = zero_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      H_IDLE: begin
        if (Go && eng.q_I) begin
          cnt_clr = 1'b1;
          if (is_zero_op(Ain_in, Bin_in)) begin
            result_d = 8'd0;
            zero_d   = 1'b1;
            state_d  = H_HOLD;
          end else begin
            ain_d   = Ain_in;
            bin_d   = Bin_in;
            zero_d  = 1'b0;
            state_d = H_REQ;
          end
        end
      end
      H_REQ: begin
        if (!eng.q_I) begin
          state_d = H_WAIT;
        end
      end
      H_WAIT: begin
        // Done wins over timeout when both land in the same cycle.
        if (eng.q_Done) begin
          result_d = eng.AB_GCD;
          state_d  = H_ACKE;
        end else begin
          cnt_en = 1'b1;
          if (cycles_cnt == TO_LAST) begin
            state_d = H_ERR;
          end
        end
      end
      H_ACKE: begin
        if (eng.q_I) begin
          state_d = H_HOLD;
        end
      end
      H_HOLD, H_ERR: begin
        if (UserAck) begin
          state_d = H_IDLE;
        end
      end
      default: state_d = H_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= H_IDLE;
      ain_q    <= 8'd0;
      bin_q    <= 8'd0;
      result_q <= 8'd0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ain_q    <= ain_d;
      bin_q    <= bin_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign q_Idle  = (state_q == H_IDLE);
  assign q_Req   = (state_q == H_REQ);
  assign q_Wait  = (state_q == H_WAIT);
  assign q_AckE  = (state_q == H_ACKE);
  assign q_Hold  = (state_q == H_HOLD);
  assign q_Err   = (state_q == H_ERR);

  assign eng.Start = q_Req;
  assign eng.Ack   = q_AckE;
  assign eng.Ain   = ain_q;
  assign eng.Bin   = bin_q;

  assign Result  = result_q;
  assign Cycles  = cycles_cnt;
  assign ZeroOp  = zero_q;
  assign Busy    = q_Req | q_Wait | q_AckE;
  assign Valid   = q_Hold;
  assign Timeout = q_Err;

endmodule
